// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive control FSM for the USB receiver datapath.
// It sequences one packet: SYNC check, per-byte FIFO write strobes, EOP
// recognition and error flagging. Define USB_RX_PID_CHECK_EN to check the
// PID byte (upper nibble must be the complement of the lower nibble) before
// it is stored.
module usb_rx_ctrl #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       packet_done,
  output logic [6:0] byte_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RCV_SYNC = 3'd1;
  localparam logic [2:0] RCV_BYTE = 3'd2;
  localparam logic [2:0] STORE    = 3'd3;
  localparam logic [2:0] EOP_CHK  = 3'd4;
  localparam logic [2:0] EOP_END  = 3'd5;
  localparam logic [2:0] ERR_WAIT = 3'd6;
  localparam logic [2:0] ERR_EOP  = 3'd7;

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  logic [2:0] state_q, state_d;
  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic       r_error_q, r_error_d;
  logic       packet_done_q, packet_done_d;
  logic [6:0] byte_count_q, byte_count_d;

  logic eop_bit;
  logic full;
  logic pid_ok;

  // EOP only counts when seen on a bit-sample strobe; it beats byte_received.
  assign eop_bit = eop & shift_enable;
  assign full    = (byte_count_q == MAX_CNT);

  // PID validity: only the first stored byte of a packet is checked.
  always_comb begin
`ifdef USB_RX_PID_CHECK_EN
    pid_ok = (byte_count_q != 7'd0) || (rcv_data[7:4] == ~rcv_data[3:0]);
`else
    pid_ok = 1'b1;
`endif
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    byte_count_d  = byte_count_q;
    r_error_d     = r_error_q;
    packet_done_d = 1'b0;
    w_enable_d    = 1'b0;
    rcving_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d      = RCV_SYNC;
          r_error_d    = 1'b0;
          byte_count_d = 7'd0;
        end
      end
      RCV_SYNC: begin
        if (eop_bit) begin
          state_d = ERR_EOP;
        end else if (byte_received) begin
          state_d = (rcv_data == SYNC_BYTE) ? RCV_BYTE : ERR_WAIT;
        end
      end
      RCV_BYTE: begin
        if (eop_bit) begin
          state_d = ERR_EOP;
        end else if (byte_received) begin
          state_d = STORE;
        end
      end
      STORE: begin
        if (full || !pid_ok) begin
          state_d = ERR_WAIT;
        end else begin
          state_d      = EOP_CHK;
          byte_count_d = byte_count_q + 7'd1;
        end
      end
      EOP_CHK: begin
        if (eop_bit) begin
          state_d = EOP_END;
        end else if (byte_received) begin
          state_d = STORE;
        end else if (shift_enable) begin
          state_d = RCV_BYTE;
        end
      end
      EOP_END: begin
        if (!eop) begin
          state_d       = IDLE;
          packet_done_d = 1'b1;
        end
      end
      ERR_WAIT: begin
        if (eop_bit) begin
          state_d = ERR_EOP;
        end
      end
      ERR_EOP: begin
        if (!eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The write strobe is registered so it lines up with the STORE cycle;
    // the full/PID decision uses the same byte_count and rcv_data STORE sees.
    w_enable_d = (state_d == STORE) && !full && pid_ok;

    if (((state_d == ERR_WAIT) || (state_d == ERR_EOP)) &&
        (state_q != ERR_WAIT) && (state_q != ERR_EOP)) begin
      r_error_d = 1'b1;
    end

    rcving_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any packet without a write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      rcving_q      <= 1'b0;
      w_enable_q    <= 1'b0;
      r_error_q     <= 1'b0;
      packet_done_q <= 1'b0;
      byte_count_q  <= 7'd0;
    end else begin
      state_q       <= state_d;
      rcving_q      <= rcving_d;
      w_enable_q    <= w_enable_d;
      r_error_q     <= r_error_d;
      packet_done_q <= packet_done_d;
      byte_count_q  <= byte_count_d;
    end
  end

  assign rcving      = rcving_q;
  assign w_enable    = w_enable_q;
  assign r_error     = r_error_q;
  assign packet_done = packet_done_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed testbench for usb_rx_ctrl: one MAX_BYTES=64 instance and one
// MAX_BYTES=2 instance driven by the same bus stimulus.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;

  logic       rcving, w_enable, r_error, packet_done;
  logic [6:0] byte_count;
  logic       rcving2, w_enable2, r_error2, packet_done2;
  logic [6:0] byte_count2;

  int checks = 0;
  int errors = 0;

  int         wcnt = 0;
  int         pdcnt = 0;
  logic [7:0] wdata [0:15];
  int         wcnt2 = 0;
  int         pdcnt2 = 0;

  always #5 clk = ~clk;

  usb_rx_ctrl #(.MAX_BYTES(64)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .rcving(rcving), .w_enable(w_enable),
    .r_error(r_error), .packet_done(packet_done), .byte_count(byte_count)
  );

  usb_rx_ctrl #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .rcving(rcving2), .w_enable(w_enable2),
    .r_error(r_error2), .packet_done(packet_done2), .byte_count(byte_count2)
  );

  // Record FIFO writes and packet completions mid-cycle.
  always @(negedge clk) begin
    if (w_enable) begin
      if (wcnt < 16) wdata[wcnt] = rcv_data;
      wcnt = wcnt + 1;
    end
    if (packet_done) pdcnt = pdcnt + 1;
    if (w_enable2) wcnt2 = wcnt2 + 1;
    if (packet_done2) pdcnt2 = pdcnt2 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_packet();
    d_edge = 1'b1;
    step();
    d_edge = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv_data      = b;
    byte_received = 1'b1;
    step();
    byte_received = 1'b0;
    step();
    step();
  endtask

  task automatic send_eop();
    eop          = 1'b1;
    shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
    step();
    eop = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
    byte_received = 1'b0; rcv_data = 8'h00;
    #2;
    checks++;
    if ({rcving, w_enable, r_error, packet_done, byte_count} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {rcving, w_enable, r_error, packet_done, byte_count});
    end
    step();
    @(negedge clk);
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_valid_packet();
    int w0, p0;
    w0 = wcnt; p0 = pdcnt;
    start_packet();
    checks++;
    if (rcving !== 1'b1) begin
      errors++; $display("FAIL rcving_after_edge: got %b required 1", rcving);
    end
    send_byte(8'h80);
    rcv_data = 8'hC3; byte_received = 1'b1;
    step();
    byte_received = 1'b0;
    checks++;
    if (w_enable !== 1'b1) begin
      errors++; $display("FAIL w_enable_latency: got %b required 1", w_enable);
    end
    step(); step();
    send_byte(8'hAA);
    eop = 1'b1; shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
    step();
    eop = 1'b0;
    step();
    checks++;
    if ({packet_done, rcving} !== 2'b10) begin
      errors++; $display("FAIL done_timing: got pd/rcving %b required 10", {packet_done, rcving});
    end
    step();
    checks++;
    if (wcnt - w0 !== 2) begin
      errors++; $display("FAIL valid_writes: got %0d required 2", wcnt - w0);
    end
    checks++;
    if ({wdata[w0], wdata[w0+1]} !== 16'hC3AA) begin
      errors++; $display("FAIL valid_data: got %h required c3aa", {wdata[w0], wdata[w0+1]});
    end
    checks++;
    if (byte_count !== 7'd2) begin
      errors++; $display("FAIL valid_count: got %0d required 2", byte_count);
    end
    checks++;
    if (pdcnt - p0 !== 1 || r_error !== 1'b0 || rcving !== 1'b0 || packet_done !== 1'b0) begin
      errors++; $display("FAIL valid_status: got pd %0d err %b rcv %b required 1 0 0", pdcnt - p0, r_error, rcving);
    end
  endtask

  task automatic test_bad_sync();
    int w0, p0;
    w0 = wcnt; p0 = pdcnt;
    start_packet();
    rcv_data = 8'h81; byte_received = 1'b1;
    step();
    byte_received = 1'b0;
    checks++;
    if (r_error !== 1'b1) begin
      errors++; $display("FAIL bad_sync_error: got %b required 1", r_error);
    end
    step();
    send_eop();
    checks++;
    if ({rcving, r_error} !== 2'b01 || wcnt != w0 || pdcnt != p0) begin
      errors++; $display("FAIL bad_sync_idle: got rcv/err %b writes %0d done %0d required 01 0 0", {rcving, r_error}, wcnt - w0, pdcnt - p0);
    end
    start_packet();
    checks++;
    if (r_error !== 1'b0) begin
      errors++; $display("FAIL error_clear: got %b required 0", r_error);
    end
  endtask

  task automatic test_eop_mid_byte();
    int p0;
    p0 = pdcnt;
    send_byte(8'h80);
    eop = 1'b1; shift_enable = 1'b1; byte_received = 1'b1; rcv_data = 8'h55;
    step();
    shift_enable = 1'b0; byte_received = 1'b0;
    checks++;
    if ({r_error, w_enable, rcving} !== 3'b101) begin
      errors++; $display("FAIL eop_mid_error: got err/wen/rcv %b required 101", {r_error, w_enable, rcving});
    end
    step();
    eop = 1'b0;
    step();
    step();
    checks++;
    if (pdcnt != p0 || rcving !== 1'b0 || r_error !== 1'b1) begin
      errors++; $display("FAIL eop_mid_end: got done %0d rcv %b err %b required 0 0 1", pdcnt - p0, rcving, r_error);
    end
  endtask

  task automatic test_overflow();
    int w0, w20, p0, p20;
    w0 = wcnt; w20 = wcnt2; p0 = pdcnt; p20 = pdcnt2;
    start_packet();
    send_byte(8'h80);
    send_byte(8'hE1);
    send_byte(8'h02);
    send_byte(8'h03);
    send_eop();
    checks++;
    if (wcnt2 - w20 !== 2 || byte_count2 !== 7'd2 || r_error2 !== 1'b1 || pdcnt2 != p20) begin
      errors++; $display("FAIL overflow_small: got writes %0d count %0d err %b done %0d required 2 2 1 0", wcnt2 - w20, byte_count2, r_error2, pdcnt2 - p20);
    end
    checks++;
    if (wcnt - w0 !== 3 || byte_count !== 7'd3 || r_error !== 1'b0 || pdcnt - p0 !== 1) begin
      errors++; $display("FAIL overflow_large: got writes %0d count %0d err %b done %0d required 3 3 0 1", wcnt - w0, byte_count, r_error, pdcnt - p0);
    end
  endtask

  task automatic test_pid_check();
    int w0, p0;
    w0 = wcnt; p0 = pdcnt;
    start_packet();
    send_byte(8'h80);
    send_byte(8'hC4);
    send_eop();
`ifdef USB_RX_PID_CHECK_EN
    checks++;
    if (wcnt != w0 || r_error !== 1'b1 || byte_count !== 7'd0 || pdcnt != p0) begin
      errors++; $display("FAIL pid_reject: got writes %0d err %b count %0d done %0d required 0 1 0 0", wcnt - w0, r_error, byte_count, pdcnt - p0);
    end
`else
    checks++;
    if (wcnt - w0 !== 1 || wdata[w0] !== 8'hC4 || r_error !== 1'b0 || pdcnt - p0 !== 1) begin
      errors++; $display("FAIL pid_unchecked: got writes %0d data %h err %b done %0d required 1 c4 0 1", wcnt - w0, wdata[w0], r_error, pdcnt - p0);
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    int w0, p0;
    start_packet();
    send_byte(8'h80);
    send_byte(8'hE1);
    rcv_data = 8'h11; byte_received = 1'b1;
    step();
    byte_received = 1'b0;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({rcving, w_enable, r_error, packet_done, byte_count} !== 11'd0) begin
      errors++; $display("FAIL reset_async: got %b required 0", {rcving, w_enable, r_error, packet_done, byte_count});
    end
    @(negedge clk);
    n_rst = 1'b1;
    step();
    w0 = wcnt; p0 = pdcnt;
    start_packet();
    send_byte(8'h80);
    send_byte(8'h5A);
    send_eop();
    checks++;
    if (wcnt - w0 !== 1 || wdata[w0] !== 8'h5A || pdcnt - p0 !== 1 || byte_count !== 7'd1 || r_error !== 1'b0) begin
      errors++; $display("FAIL after_reset: got writes %0d data %h done %0d count %0d err %b required 1 5a 1 1 0", wcnt - w0, wdata[w0], pdcnt - p0, byte_count, r_error);
    end
  endtask

  initial begin
    test_reset();
    test_valid_packet();
    test_bad_sync();
    test_eop_mid_byte();
    test_overflow();
    test_pid_check();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive control unit for the USB receiver datapath. Sequences one packet's reception: it detects the start of a packet, validates the SYNC byte, strobes each received data byte into the RX FIFO and recognises end-of-packet using the registered SE0 flag from the EOP detector. It also flags protocol errors. It sits between the bit-level front end (edge detector, EOP detector, bit-timer, shift register) and the RX FIFO.

## Interface
Parameters:
- MAX_BYTES, 64: maximum data bytes stored per packet, including the PID; legal range 1..127.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- d_edge  in  1  one-cycle pulse on a D+/D- transition
- eop  in  1  registered SE0 flag; 1 while the bus is in SE0
- shift_enable  in  1  one-cycle bit-sample strobe from the bit timer
- byte_received  in  1  one-cycle pulse when the shifter holds 8 new bits
- rcv_data  in  8  shifter contents, valid in the byte_received cycle
- rcving  out  1  high while a packet is in progress
- w_enable  out  1  one-cycle FIFO write strobe for rcv_data
- r_error  out  1  sticky receive-error flag
- packet_done  out  1  one-cycle pulse on error-free packet completion
- byte_count  out  7  data bytes written in the current packet

## Operation
- States: IDLE, RCV_SYNC, RCV_BYTE, STORE, EOP_CHK, EOP_END, ERR_WAIT, ERR_EOP. The state register and all outputs are registered.
- IDLE: on d_edge, go to RCV_SYNC. In the same transition, clear r_error and clear byte_count.
- RCV_SYNC:
  - eop&shift_enable goes to ERR_EOP.
  - byte_received with rcv_data==8'h80 goes to RCV_BYTE.
  - byte_received with any other value goes to ERR_WAIT.
- RCV_BYTE:
  - byte_received goes to STORE.
  - eop&shift_enable (EOP mid-byte) goes to ERR_EOP.
- STORE: lasts one cycle.
  - w_enable=1; byte_count increments.
  - If the pre-increment byte_count equals MAX_BYTES, the write is suppressed (w_enable=0) and the state goes to ERR_WAIT.
  - Otherwise the state goes to EOP_CHK.
- EOP_CHK:
  - eop&shift_enable goes to EOP_END.
  - shift_enable with eop=0 goes to RCV_BYTE.
  - byte_received goes to STORE; this has priority over shift_enable.
- EOP_END: when eop=0 (bus back to J), go to IDLE and pulse packet_done.
- ERR_WAIT: wait for eop&shift_enable, then go to ERR_EOP.
- ERR_EOP: when eop=0, go to IDLE. packet_done stays 0.
- Output decode:
  - rcving=1 in every state except IDLE.
  - r_error is set on entry to ERR_WAIT or ERR_EOP. It holds through IDLE until the next d_edge.
- byte_count saturates at MAX_BYTES and never wraps.
- Simultaneous events:
  - eop&shift_enable and byte_received in the same cycle: eop wins in every state.
  - d_edge is ignored outside IDLE.

## Timing
- Reset values: state IDLE, rcving 0, w_enable 0, r_error 0, packet_done 0, byte_count 0. Reset mid-packet aborts immediately with no write.
- d_edge at cycle N gives rcving=1 at N+1.
- byte_received at cycle N in RCV_BYTE or EOP_CHK gives w_enable=1 at N+1. rcv_data must stay stable through N+1, because the FIFO samples it with w_enable.
- eop falling at cycle N in EOP_END gives packet_done=1 and rcving=0 at N+1.
- Minimum packet: SYNC, then one byte, then EOP. This yields exactly one w_enable.

## Configuration
- USB_RX_PID_CHECK_EN defined:
  - In STORE with byte_count==0 (the PID byte), require rcv_data[7:4] == ~rcv_data[3:0].
  - On mismatch: suppress w_enable, leave byte_count at 0, set r_error and go to ERR_WAIT.
- Undefined: the PID byte is stored unchecked, like any data byte.

## Test plan
- Valid packet: SYNC 8'h80, then 8'hC3 and 8'hAA, then EOP → two w_enable pulses with rcv_data C3 and AA, byte_count=2, one packet_done, r_error=0, rcving=0 after the bus returns to J.
- Bad SYNC: first byte 8'h81 → no w_enable, r_error=1 from ERR_WAIT entry, IDLE after EOP; the next d_edge clears r_error.
- EOP mid-byte: SYNC 8'h80, then eop&shift_enable before byte_received → ERR_EOP, r_error=1, no packet_done.
- Overflow: with MAX_BYTES=2, send 3 data bytes → exactly 2 w_enable pulses, byte_count=2, r_error=1.
- PID check: with the macro defined, PID 8'hC4 → no write and r_error=1; with the macro undefined, the same stimulus writes C4 and the packet completes with no error.
- Reset mid-packet: assert n_rst during RCV_BYTE → all outputs 0 asynchronously; the next packet is received normally.
